fetch_prefetch_queue: RTL and testbench

FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

---
 rtl/fetch_prefetch_queue_if.sv | 33 +++
 rtl/fetch_prefetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_prefetch_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch/prefetch-queue bus: fetch control, memory port and consumer handshake.
// The slave modport is the queue itself; the master drives control and memory data.
interface fetch_prefetch_queue_if #(
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          enable_fetch;
    logic          br_taken;
    logic [AW-1:0] taddr;
    logic [DW-1:0] instr_dout;
    logic          out_ready;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    logic          instrmem_rd;
    logic          out_valid;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_npc;
    logic [CW-1:0] count;

    modport master (
        output enable_fetch, br_taken, taddr, instr_dout, out_ready,
        input  pc, npc, instrmem_rd, out_valid, out_instr, out_pc, out_npc, count
    );

    modport slave (
        input  enable_fetch, br_taken, taddr, instr_dout, out_ready,
        output pc, npc, instrmem_rd, out_valid, out_instr, out_pc, out_npc, count
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue and branch flush.
// Define FETCH_BYPASS_EN to forward memory data straight to the output when the queue is empty.
module fetch_prefetch_queue #(
    parameter int unsigned  AW       = 16,
    parameter int unsigned  DW       = 16,
    parameter int unsigned  DEPTH    = 4,
    parameter bit [AW-1:0]  RESET_PC = AW'('h3000)
) (
    input  logic                  clock,
    input  logic                  reset,
    fetch_prefetch_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    logic [AW-1:0] pc_q;
    logic [AW-1:0] tag_q;
    logic          inflight_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    entry_t        mem_q [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic          q_valid;
    logic [AW-1:0] out_pc_c;
    entry_t        head;
`ifdef FETCH_BYPASS_EN
    logic          bypass;
`endif

    // Issue/push/pop decisions; a flush suppresses all three.
    always_comb begin
        q_valid = (count_q != '0);
        head    = mem_q[rd_ptr_q];
        issue   = reset & bus.enable_fetch & ~bus.br_taken &
                  (((CW+1)'(count_q) + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH));
        pop     = q_valid & bus.out_ready & ~bus.br_taken;
`ifdef FETCH_BYPASS_EN
        bypass  = ~q_valid & inflight_q & ~bus.br_taken;
        push    = inflight_q & ~bus.br_taken & ~(bypass & bus.out_ready);
`else
        push    = inflight_q & ~bus.br_taken;
`endif
    end

    // Output drive; only the bypass build has a path from instr_dout to the head.
    always_comb begin
        bus.pc          = pc_q;
        bus.npc         = pc_q + AW'(1);
        bus.instrmem_rd = issue;
        bus.count       = count_q;
`ifdef FETCH_BYPASS_EN
        bus.out_valid   = q_valid | bypass;
        bus.out_instr   = bypass ? bus.instr_dout : head.instr;
        out_pc_c        = bypass ? tag_q : head.pc;
`else
        bus.out_valid   = q_valid;
        bus.out_instr   = head.instr;
        out_pc_c        = head.pc;
`endif
        bus.out_pc      = out_pc_c;
        bus.out_npc     = out_pc_c + AW'(1);
    end

    // Fetch state and queue bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            tag_q      <= RESET_PC;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else if (bus.br_taken) begin
            pc_q       <= bus.taddr;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (issue) begin
                pc_q  <= pc_q + AW'(1);
                tag_q <= pc_q;
            end
            inflight_q <= issue;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Queue storage carries no reset; contents are qualified by count.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= '{pc: tag_q, instr: bus.instr_dout};
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(push && !pop && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a 16-bit default instance and an 8-bit wrap instance.
module tb_fetch_prefetch_queue;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   rd_seen = 0;

    always #5 clock = ~clock;

    fetch_prefetch_queue_if #(.AW(16), .DW(16), .DEPTH(4)) bus ();
    fetch_prefetch_queue_if #(.AW(8),  .DW(8),  .DEPTH(4)) bus8 ();

    fetch_prefetch_queue #(.AW(16), .DW(16), .DEPTH(4), .RESET_PC(16'h3000)) dut (
        .clock(clock), .reset(reset), .bus(bus));
    fetch_prefetch_queue #(.AW(8), .DW(8), .DEPTH(4), .RESET_PC(8'hFF)) dut8 (
        .clock(clock), .reset(reset), .bus(bus8));

    function automatic logic [15:0] f16(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    function automatic logic [7:0] f8(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // Memory model: data appears the cycle after the read strobe, junk otherwise.
    always @(posedge clock) begin
        bus.instr_dout  <= bus.instrmem_rd  ? f16(bus.pc)  : 16'hDEAD;
        bus8.instr_dout <= bus8.instrmem_rd ? f8(bus8.pc)  : 8'hEE;
    end

    task automatic cyc();
        @(negedge clock);
        if (bus.instrmem_rd) rd_seen++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.enable_fetch = 1'b0; bus.br_taken = 1'b0; bus.taddr = '0; bus.out_ready = 1'b0;
        bus8.enable_fetch = 1'b0; bus8.br_taken = 1'b0; bus8.taddr = '0; bus8.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        rd_seen = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.enable_fetch = 1'b1;
        cyc();
        n_cmp++; if (bus.pc !== 16'h3000) begin n_fail++; $display("FAIL reset_pc got %h want 3000", bus.pc); end
        n_cmp++; if (bus.npc !== 16'h3001) begin n_fail++; $display("FAIL reset_npc got %h want 3001", bus.npc); end
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.instrmem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %b want 0", bus.instrmem_rd); end
        bus.enable_fetch = 1'b0;
    endtask

    task automatic test_stream();
        logic [15:0] exp_pc;
        do_reset();
        bus.enable_fetch = 1'b1;
        bus.out_ready    = 1'b1;
        #1;
        n_cmp++; if (bus.instrmem_rd !== 1'b1) begin n_fail++; $display("FAIL stream_first_rd got %b want 1", bus.instrmem_rd); end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            exp_pc = 16'h3000 + 16'(k);
            n_cmp++; if (bus.pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d] got %h want %h", k, bus.pc, exp_pc); end
            if (k == 1) begin
                n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid got %b want 0", bus.out_valid); end
            end else begin
                exp_pc = 16'h3000 + 16'(k - 2);
                n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b want 1", k, bus.out_valid); end
                n_cmp++; if (bus.out_pc !== exp_pc) begin n_fail++; $display("FAIL stream_out_pc[%0d] got %h want %h", k, bus.out_pc, exp_pc); end
                n_cmp++; if (bus.out_npc !== exp_pc + 16'd1) begin n_fail++; $display("FAIL stream_out_npc[%0d] got %h want %h", k, bus.out_npc, exp_pc + 16'd1); end
                n_cmp++; if (bus.out_instr !== f16(exp_pc)) begin n_fail++; $display("FAIL stream_instr[%0d] got %h want %h", k, bus.out_instr, f16(exp_pc)); end
            end
        end
    endtask

    task automatic test_fill_refill();
        do_reset();
        bus.enable_fetch = 1'b1;
        bus.out_ready    = 1'b0;
        repeat (8) cyc();
        n_cmp++; if (rd_seen != 4) begin n_fail++; $display("FAIL fill_reads got %0d want 4", rd_seen); end
        n_cmp++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", bus.count); end
        n_cmp++; if (bus.instrmem_rd !== 1'b0) begin n_fail++; $display("FAIL fill_rd got %b want 0", bus.instrmem_rd); end
        n_cmp++; if (bus.pc !== 16'h3004) begin n_fail++; $display("FAIL fill_pc got %h want 3004", bus.pc); end
        n_cmp++; if (bus.out_pc !== 16'h3000) begin n_fail++; $display("FAIL fill_head got %h want 3000", bus.out_pc); end
        rd_seen = 0;
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL refill_pop_count got %0d want 3", bus.count); end
        cyc();
        n_cmp++; if (bus.pc !== 16'h3005) begin n_fail++; $display("FAIL refill_pc got %h want 3005", bus.pc); end
        cyc();
        n_cmp++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL refill_count got %0d want 4", bus.count); end
        n_cmp++; if (bus.out_pc !== 16'h3001) begin n_fail++; $display("FAIL refill_head got %h want 3001", bus.out_pc); end
        n_cmp++; if (rd_seen != 1) begin n_fail++; $display("FAIL refill_reads got %0d want 1", rd_seen); end
        cyc();
        n_cmp++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL refill_hold_count got %0d want 4", bus.count); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.enable_fetch = 1'b1;
        repeat (4) cyc();
        n_cmp++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d want 3", bus.count); end
        bus.br_taken = 1'b1;
        bus.taddr    = 16'h4100;
        #1;
        n_cmp++; if (bus.instrmem_rd !== 1'b0) begin n_fail++; $display("FAIL flush_rd got %b want 0", bus.instrmem_rd); end
        cyc();
        bus.br_taken  = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.pc !== 16'h4100) begin n_fail++; $display("FAIL flush_pc got %h want 4100", bus.pc); end
        cyc();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.pc !== 16'h4101) begin n_fail++; $display("FAIL flush_pc2 got %h want 4101", bus.pc); end
        cyc();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_new_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 16'h4100) begin n_fail++; $display("FAIL flush_out_pc got %h want 4100", bus.out_pc); end
        n_cmp++; if (bus.out_instr !== f16(16'h4100)) begin n_fail++; $display("FAIL flush_instr got %h want %h", bus.out_instr, f16(16'h4100)); end
    endtask

    task automatic test_hold();
        do_reset();
        bus.enable_fetch = 1'b1;
        cyc();
        bus.enable_fetch = 1'b0;
        cyc();
        n_cmp++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL hold_count got %0d want 1", bus.count); end
        n_cmp++; if (bus.pc !== 16'h3001) begin n_fail++; $display("FAIL hold_pc got %h want 3001", bus.pc); end
        n_cmp++; if (bus.out_instr !== f16(16'h3000)) begin n_fail++; $display("FAIL hold_instr got %h want %h", bus.out_instr, f16(16'h3000)); end
        n_cmp++; if (bus.instrmem_rd !== 1'b0) begin n_fail++; $display("FAIL hold_rd got %b want 0", bus.instrmem_rd); end
        cyc();
        n_cmp++; if (bus.pc !== 16'h3001) begin n_fail++; $display("FAIL hold_pc2 got %h want 3001", bus.pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.enable_fetch = 1'b1;
        repeat (3) cyc();
        n_cmp++; if (bus.count !== 3'd2) begin n_fail++; $display("FAIL areset_pre_count got %0d want 2", bus.count); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.pc !== 16'h3000) begin n_fail++; $display("FAIL areset_pc got %h want 3000", bus.pc); end
        n_cmp++; if (bus.instrmem_rd !== 1'b0) begin n_fail++; $display("FAIL areset_rd got %b want 0", bus.instrmem_rd); end
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        n_cmp++; if (bus8.pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_start_pc got %h want ff", bus8.pc); end
        n_cmp++; if (bus8.npc !== 8'h00) begin n_fail++; $display("FAIL wrap_npc got %h want 00", bus8.npc); end
        bus8.enable_fetch = 1'b1;
        cyc();
        bus8.enable_fetch = 1'b0;
        n_cmp++; if (bus8.pc !== 8'h00) begin n_fail++; $display("FAIL wrap_pc got %h want 00", bus8.pc); end
        n_cmp++; if (bus8.npc !== 8'h01) begin n_fail++; $display("FAIL wrap_npc2 got %h want 01", bus8.npc); end
        cyc();
        n_cmp++; if (bus8.out_pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_out_pc got %h want ff", bus8.out_pc); end
        n_cmp++; if (bus8.out_npc !== 8'h00) begin n_fail++; $display("FAIL wrap_out_npc got %h want 00", bus8.out_npc); end
        n_cmp++; if (bus8.out_instr !== f8(8'hFF)) begin n_fail++; $display("FAIL wrap_instr got %h want %h", bus8.out_instr, f8(8'hFF)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_refill();
        test_flush();
        test_hold();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
